// File: rtl/spgd_pkg.sv
// Shared definitions for the SPGD measurement path: state encoding, default
// ADC/window sizing and the derived accumulator width.
package spgd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DISCARD = 2'd1,
        ST_ACCUM   = 2'd2,
        ST_DONE    = 2'd3
    } spgd_state_e;

    localparam int ADC_WIDTH_DEF = 14;
    localparam int N_LOG2_DEF    = 10;

    // Summing 2^n_log2 samples of adc_w bits grows the result by n_log2 bits.
    function automatic int acc_width(input int adc_w, input int n_log2);
        return adc_w + n_log2;
    endfunction

endpackage

// File: rtl/spgd_window_counter.sv
// Loadable down-counter with terminal-count flag; times both the discard
// phase and the accumulation window.
module spgd_window_counter #(
    parameter int WIDTH = 10
) (
    input  logic             ADC_CLK,
    input  logic             RST_N,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge ADC_CLK or negedge RST_N) begin
        if (!RST_N) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/spgd_adc_accum.sv
// SPGD metric stage: integrates a window of signed ADC samples into J_SUM,
// holds J+ / J- and produces the registered difference DELTA_J.
module spgd_adc_accum
    import spgd_pkg::*;
#(
    parameter int ADC_WIDTH = ADC_WIDTH_DEF,
    parameter int N_LOG2    = N_LOG2_DEF,
    parameter int DISCARD   = 2,
    parameter int ACC_WIDTH = acc_width(ADC_WIDTH, N_LOG2)
) (
    input  logic                        ADC_CLK,
    input  logic                        RST_N,
    input  logic                        ADC_EN,
    input  logic signed [ADC_WIDTH-1:0] ADC_DATA,
    input  logic                        REG_RST,
    input  logic                        J_P_WRT,
    input  logic                        J_M_WRT,
    output logic                        ADC_DONE,
    output logic signed [ACC_WIDTH-1:0] J_SUM,
    output logic signed [ACC_WIDTH-1:0] J_P,
    output logic signed [ACC_WIDTH-1:0] J_M,
    output logic signed [ACC_WIDTH:0]   DELTA_J,
    output logic                        ADC_CLIP
);

    // The counter must hold both DISCARD-1 and 2^N_LOG2-1.
    localparam int CNT_W = (N_LOG2 > $clog2(DISCARD + 1)) ? N_LOG2 : $clog2(DISCARD + 1);
    localparam logic [CNT_W-1:0] DISCARD_LOAD = CNT_W'(DISCARD - 1);
    localparam logic [CNT_W-1:0] WINDOW_LOAD  = CNT_W'((1 << N_LOG2) - 1);

    localparam logic signed [ADC_WIDTH-1:0] ADC_MAX = {1'b0, {(ADC_WIDTH-1){1'b1}}};
    localparam logic signed [ADC_WIDTH-1:0] ADC_MIN = {1'b1, {(ADC_WIDTH-1){1'b0}}};

    spgd_state_e state, state_nxt;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_dec;
    logic             cnt_tc;
    logic             win_start;
    logic             acc_add;
    logic             win_end;

    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] sample_ext;
    logic signed [ACC_WIDTH-1:0] acc_sum;

    assign sample_ext = {{(ACC_WIDTH-ADC_WIDTH){ADC_DATA[ADC_WIDTH-1]}}, ADC_DATA};
    assign acc_sum    = acc + sample_ext;

    spgd_window_counter #(
        .WIDTH (CNT_W)
    ) u_window_counter (
        .ADC_CLK  (ADC_CLK),
        .RST_N    (RST_N),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .tc       (cnt_tc)
    );

    always_ff @(posedge ADC_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_val   = '0;
        cnt_dec   = 1'b0;
        win_start = 1'b0;
        acc_add   = 1'b0;
        win_end   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ADC_EN) begin
                    state_nxt = ST_DISCARD;
                    cnt_load  = 1'b1;
                    cnt_val   = DISCARD_LOAD;
                    win_start = 1'b1;
                end
            end
            ST_DISCARD: begin
                if (!ADC_EN) begin
                    state_nxt = ST_IDLE;
                end else if (cnt_tc) begin
                    state_nxt = ST_ACCUM;
                    cnt_load  = 1'b1;
                    cnt_val   = WINDOW_LOAD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_ACCUM: begin
                if (!ADC_EN) begin
                    state_nxt = ST_IDLE;
                end else begin
                    acc_add = 1'b1;
                    if (cnt_tc) begin
                        state_nxt = ST_DONE;
                        win_end   = 1'b1;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (!ADC_EN) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ADC_DONE is registered from the next state so it leaves the block glitch-free.
    always_ff @(posedge ADC_CLK or negedge RST_N) begin
        if (!RST_N) begin
            acc      <= '0;
            ADC_CLIP <= 1'b0;
            ADC_DONE <= 1'b0;
            J_SUM    <= '0;
            J_P      <= '0;
            J_M      <= '0;
            DELTA_J  <= '0;
        end else begin
            ADC_DONE <= (state_nxt == ST_DONE);

            if (win_start) begin
                acc      <= '0;
                ADC_CLIP <= 1'b0;
            end else if (acc_add) begin
                acc <= acc_sum;
                if ((ADC_DATA == ADC_MAX) || (ADC_DATA == ADC_MIN)) begin
                    ADC_CLIP <= 1'b1;
                end
            end

            // Strobes see the pre-edge J_SUM, so a load coincident with window end takes the old sum.
            if (REG_RST) begin
                J_SUM   <= '0;
                J_P     <= '0;
                J_M     <= '0;
                DELTA_J <= '0;
            end else begin
                if (win_end) begin
                    J_SUM <= acc_sum;
                end
                if (J_P_WRT) begin
                    J_P <= J_SUM;
                end
                if (J_M_WRT) begin
                    J_M <= J_SUM;
                end
                DELTA_J <= {J_P[ACC_WIDTH-1], J_P} - {J_M[ACC_WIDTH-1], J_M};
            end
        end
    end

endmodule

// File: tb/tb_spgd_adc_accum.sv
// Directed bench: a small-window instance (N_LOG2=4) for table vectors and
// register corner cases, plus a default-sized instance for the full window.
module tb_spgd_adc_accum;

    localparam int SD = 2;   // discard length
    localparam int SW = 16;  // small window length

    typedef struct {
        int first;
        int rest;
        int exp_sum;
        bit exp_clip;
    } vec_t;

    logic clk;
    logic rst_n;

    logic                s_en, s_reg_rst, s_jp, s_jm;
    logic signed [13:0]  s_data;
    logic                s_done, s_clip;
    logic signed [17:0]  s_sum, s_jpv, s_jmv;
    logic signed [18:0]  s_delta;

    logic                d_en, d_reg_rst, d_jp, d_jm;
    logic signed [13:0]  d_data;
    logic                d_done, d_clip;
    logic signed [23:0]  d_sum, d_jpv, d_jmv;
    logic signed [24:0]  d_delta;

    int checks = 0;
    int errors = 0;

    spgd_adc_accum #(
        .ADC_WIDTH (14),
        .N_LOG2    (4),
        .DISCARD   (SD)
    ) u_small (
        .ADC_CLK  (clk),
        .RST_N    (rst_n),
        .ADC_EN   (s_en),
        .ADC_DATA (s_data),
        .REG_RST  (s_reg_rst),
        .J_P_WRT  (s_jp),
        .J_M_WRT  (s_jm),
        .ADC_DONE (s_done),
        .J_SUM    (s_sum),
        .J_P      (s_jpv),
        .J_M      (s_jmv),
        .DELTA_J  (s_delta),
        .ADC_CLIP (s_clip)
    );

    spgd_adc_accum u_def (
        .ADC_CLK  (clk),
        .RST_N    (rst_n),
        .ADC_EN   (d_en),
        .ADC_DATA (d_data),
        .REG_RST  (d_reg_rst),
        .J_P_WRT  (d_jp),
        .J_M_WRT  (d_jm),
        .ADC_DONE (d_done),
        .J_SUM    (d_sum),
        .J_P      (d_jpv),
        .J_M      (d_jmv),
        .DELTA_J  (d_delta),
        .ADC_CLIP (d_clip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raises s_en and feeds sample 0 = first, samples 1..15 = rest, junk during
    // discard. Returns the edge index (0 = edge that first sees s_en) at which
    // s_done is observed high, or -1 on timeout. Optionally strobes J_P_WRT on
    // the completing edge.
    task automatic run_small(input int first, input int rest, input bit jp_at_end,
                             output int lat);
        int i;
        lat    = -1;
        s_en   = 1'b1;
        s_data = 14'sd1000;
        for (int j = 0; j < 60 && lat < 0; j++) begin
            tick();
            s_jp = 1'b0;
            if (s_done) begin
                lat = j;
            end else begin
                i = j - SD;
                if (i >= 0 && i < SW) s_data = (i == 0) ? 14'(first) : 14'(rest);
                else                  s_data = 14'sd1000;
                if (jp_at_end && j == SD + SW - 1) s_jp = 1'b1;
            end
        end
    endtask

    vec_t vecs[8];
    int   lat;

    initial begin
        vecs[0] = '{3,     3,     48,      1'b0};
        vecs[1] = '{8191,  0,     8191,    1'b1};
        vecs[2] = '{-8192, -1,    -8207,   1'b1};
        vecs[3] = '{-5,    -5,    -80,     1'b0};
        vecs[4] = '{100,   0,     100,     1'b0};
        vecs[5] = '{-40,   0,     -40,     1'b0};
        vecs[6] = '{8190,  8190,  131040,  1'b0};
        vecs[7] = '{-8192, -8192, -131072, 1'b1};

        rst_n = 1'b0;
        s_en = 1'b0; s_data = '0; s_reg_rst = 1'b0; s_jp = 1'b0; s_jm = 1'b0;
        d_en = 1'b0; d_data = '0; d_reg_rst = 1'b0; d_jp = 1'b0; d_jm = 1'b0;
        #2;
        check("rst_done",  s_done,  0);
        check("rst_sum",   s_sum,   0);
        check("rst_jp",    s_jpv,   0);
        check("rst_jm",    s_jmv,   0);
        check("rst_delta", s_delta, 0);
        check("rst_clip",  s_clip,  0);
        check("rst_d_done", d_done, 0);
        check("rst_d_sum",  d_sum,  0);
        #20 rst_n = 1'b1;
        tick();

        // Table-driven windows on the small instance.
        foreach (vecs[n]) begin
            run_small(vecs[n].first, vecs[n].rest, 1'b0, lat);
            check($sformatf("vec%0d_latency", n), lat, SD + SW);
            check($sformatf("vec%0d_sum", n), s_sum, vecs[n].exp_sum);
            check($sformatf("vec%0d_clip", n), s_clip, vecs[n].exp_clip);
            tick(); tick();
            check($sformatf("vec%0d_done_held", n), s_done, 1);
            s_en = 1'b0;
            tick();
            check($sformatf("vec%0d_done_drop", n), s_done, 0);
            check($sformatf("vec%0d_sum_held", n), s_sum, vecs[n].exp_sum);
        end

        // J+ / J- loads and DELTA_J lag.
        run_small(100, 0, 1'b0, lat);
        s_jp = 1'b1; tick(); s_jp = 1'b0;
        check("jp_load", s_jpv, 100);
        s_en = 1'b0; tick();
        run_small(-40, 0, 1'b0, lat);
        s_jm = 1'b1; tick(); s_jm = 1'b0;
        check("jm_load", s_jmv, -40);
        check("jp_kept", s_jpv, 100);
        check("delta_lag", s_delta, 100);
        tick();
        check("delta_140", s_delta, 140);
        s_en = 1'b0; tick();

        // Strobe on the completing edge takes the old J_SUM.
        run_small(3, 3, 1'b1, lat);
        check("jp_old_sum", s_jpv, -40);
        check("sum_new", s_sum, 48);
        s_jp = 1'b1; s_jm = 1'b1; tick(); s_jp = 1'b0; s_jm = 1'b0;
        check("both_jp", s_jpv, 48);
        check("both_jm", s_jmv, 48);
        s_en = 1'b0; tick();
        run_small(-5, -5, 1'b0, lat);
        s_jm = 1'b1; tick(); s_jm = 1'b0;
        tick();
        check("delta_128", s_delta, 128);

        // REG_RST beats a simultaneous J_P_WRT.
        s_reg_rst = 1'b1; s_jp = 1'b1; tick(); s_reg_rst = 1'b0; s_jp = 1'b0;
        check("regrst_jp",    s_jpv,   0);
        check("regrst_jm",    s_jmv,   0);
        check("regrst_sum",   s_sum,   0);
        check("regrst_delta", s_delta, 0);
        tick();
        check("regrst_delta_next", s_delta, 0);
        s_en = 1'b0; tick();

        // Abort mid-ACCUM after 5 samples.
        run_small(3, 3, 1'b0, lat);
        s_en = 1'b0; tick();
        s_en = 1'b1; s_data = 14'sd1000;
        for (int j = 0; j <= SD + 5; j++) begin
            tick();
            s_data = (j >= SD) ? 14'sd7 : 14'sd1000;
        end
        s_en = 1'b0;
        tick();
        check("abort_done", s_done, 0);
        check("abort_sum",  s_sum,  48);
        repeat (3) tick();
        check("abort_done_later", s_done, 0);
        run_small(-5, -5, 1'b0, lat);
        check("after_abort_lat", lat, SD + SW);
        check("after_abort_sum", s_sum, -80);
        s_en = 1'b0; tick();

        // Asynchronous reset mid-window.
        s_en = 1'b1; s_data = 14'sd8191; s_jp = 1'b1;
        tick();
        s_jp = 1'b0;
        repeat (7) tick();
        check("pre_rst_clip", s_clip, 1);
        check("pre_rst_jp",   s_jpv,  -80);
        rst_n = 1'b0;
        #1;
        check("arst_done",  s_done,  0);
        check("arst_sum",   s_sum,   0);
        check("arst_jp",    s_jpv,   0);
        check("arst_jm",    s_jmv,   0);
        check("arst_delta", s_delta, 0);
        check("arst_clip",  s_clip,  0);
        #2 rst_n = 1'b1;
        s_en = 1'b0;
        tick();
        run_small(3, 3, 1'b0, lat);
        check("post_rst_lat", lat, SD + SW);
        check("post_rst_sum", s_sum, 48);
        s_en = 1'b0; tick();

        // Full default window, alternating full-scale codes.
        lat  = -1;
        d_en = 1'b1;
        d_data = 14'(-8192);
        for (int j = 0; j < 1100 && lat < 0; j++) begin
            tick();
            if (d_done) lat = j;
            d_data = (j % 2 == 1) ? 14'(-8192) : 14'sd8191;
        end
        check("def_latency", lat, 1026);
        check("def_sum",  d_sum,  -512);
        check("def_clip", d_clip, 1);
        d_en = 1'b0;
        tick();
        check("def_done_drop", d_done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
